// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared select codes, glyph constants and scan state type for 7-segment drivers
package seg7_pkg;

  localparam logic [1:0] SEL_TENS = 2'b11;
  localparam logic [1:0] SEL_ONES = 2'b10;
  localparam logic [1:0] SEL_FRAC = 2'b01;
  localparam logic [1:0] SEL_SYM  = 2'b00;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [3:0] CODE_C    = 4'd10;
  localparam logic [3:0] CODE_DASH = 4'd15;

  typedef enum logic [1:0] {BLANK, LATCH, SHOW} state_t;

  // Scan order is tens -> ones -> fraction -> symbol -> tens.
  function automatic logic [1:0] next_select(input logic [1:0] sel);
    case (sel)
      SEL_TENS: next_select = SEL_ONES;
      SEL_ONES: next_select = SEL_FRAC;
      SEL_FRAC: next_select = SEL_SYM;
      default:  next_select = SEL_TENS;
    endcase
  endfunction

  function automatic logic [3:0] anode_mask(input logic [1:0] sel);
    case (sel)
      SEL_TENS: anode_mask = 4'b0111;
      SEL_ONES: anode_mask = 4'b1011;
      SEL_FRAC: anode_mask = 4'b1101;
      default:  anode_mask = 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit digit code to active-low {g,f,e,d,c,b,a} glyph
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:      o_seg = 7'h40;
      4'd1:      o_seg = 7'h79;
      4'd2:      o_seg = 7'h24;
      4'd3:      o_seg = 7'h30;
      4'd4:      o_seg = 7'h19;
      4'd5:      o_seg = 7'h12;
      4'd6:      o_seg = 7'h02;
      4'd7:      o_seg = 7'h78;
      4'd8:      o_seg = 7'h00;
      4'd9:      o_seg = 7'h10;
      CODE_C:    o_seg = SEG_C;
      CODE_DASH: o_seg = SEG_DASH;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit common-anode multiplexed scanner with per-slot blank/latch/show sequencing
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] decimal_digit,
  output logic [1:0] select,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] digit_en,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(REFRESH_DIV - 2);

  if (REFRESH_DIV < 4 || REFRESH_DIV > 2**20) begin : g_div_range_check
    $error("seven_seg_scanner: REFRESH_DIV out of range 4..2^20");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_select;
  logic [3:0]       r_digit;
  state_t           r_state;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_digit_en;
  logic             r_frame_tick;
  logic [6:0]       w_glyph;

  seg7_decode u_decode (
    .i_code (r_digit),
    .o_seg  (w_glyph)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_select     <= SEL_TENS;
      r_digit      <= 4'd0;
      r_state      <= BLANK;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_digit_en   <= 4'hF;
      r_frame_tick <= 1'b0;
    end else if (!enable) begin
      r_cnt        <= '0;
      r_select     <= SEL_TENS;
      r_state      <= BLANK;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_digit_en   <= 4'hF;
      r_frame_tick <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lands on the symbol slot's last cycle.
      r_frame_tick <= (r_select == SEL_SYM) && (r_cnt == CNT_PENULT);

      if (r_cnt == CNT_MAX) begin
        r_cnt    <= '0;
        r_select <= next_select(r_select);
        r_state  <= BLANK;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_state <= (r_state == BLANK) ? LATCH : SHOW;
      end

      if (r_state == BLANK)
        r_digit <= decimal_digit;

      if (r_state == SHOW) begin
        r_digit_en <= anode_mask(r_select);
        r_dp       <= (r_select != SEL_ONES);
        r_seg      <= (r_select == SEL_TENS && r_digit == 4'd0) ? SEG_BLANK : w_glyph;
      end else begin
        r_digit_en <= 4'hF;
        r_dp       <= 1'b1;
        r_seg      <= SEG_BLANK;
      end
    end
  end

  assign select     = r_select;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign digit_en   = r_digit_en;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] decimal_digit;
  logic [1:0] select;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit_en;
  logic       frame_tick;

  logic [3:0] tbl [4];
  logic       ovr_en;
  logic [3:0] ovr_val;

  int n_cmp = 0;
  int n_err = 0;
  int ft_cnt = 0;
  int ft0;

  // Upstream selector: returns the digit for whatever select the scanner drives.
  assign decimal_digit = ovr_en ? ovr_val : tbl[select];

  seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .decimal_digit (decimal_digit),
    .select        (select),
    .seg           (seg),
    .dp            (dp),
    .digit_en      (digit_en),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick === 1'b1) ft_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] de, input logic [6:0] sg, input logic d);
    chk({tag, ".digit_en"}, 32'(digit_en), 32'(de));
    chk({tag, ".seg"}, 32'(seg), 32'(sg));
    chk({tag, ".dp"}, 32'(dp), 32'(d));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ovr_en = 1'b0; ovr_val = 4'd0;
    tbl[3] = 4'd2; tbl[2] = 4'd3; tbl[1] = 4'd5; tbl[0] = 4'd10;

    cyc(2);
    chk_out("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset.select", 32'(select), 32'h3);
    chk("reset.frame_tick", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    ft0 = ft_cnt;

    cyc(1); chk_out("s1_blank", 4'hF, 7'h7F, 1'b1);
    chk("s1.select", 32'(select), 32'h3);
    cyc(2); chk_out("s3_tens", 4'h7, 7'h24, 1'b1);
    cyc(1); chk_out("s4_tens", 4'h7, 7'h24, 1'b1);
    chk("s4.select", 32'(select), 32'h2);
    cyc(2); chk_out("s6_latch", 4'hF, 7'h7F, 1'b1);
    cyc(1); chk_out("s7_ones", 4'hB, 7'h30, 1'b0);
    cyc(1); chk("s8.select", 32'(select), 32'h1);
    cyc(3); chk_out("s11_frac", 4'hD, 7'h12, 1'b1);
    cyc(4); chk_out("s15_sym", 4'hE, 7'h46, 1'b1);
    chk("s15.frame_tick", 32'(frame_tick), 32'h1);
    cyc(1); chk("s16.frame_tick", 32'(frame_tick), 32'h0);
    chk("s16.select", 32'(select), 32'h3);
    cyc(16);
    chk("frame_ticks_32cyc", 32'(ft_cnt - ft0), 32'd2);

    tbl[3] = 4'd0; tbl[2] = 4'd7;
    cyc(3); chk_out("s35_tens_zero", 4'h7, 7'h7F, 1'b1);
    cyc(2); chk_out("s37_ones_blank", 4'hF, 7'h7F, 1'b1);
    cyc(1); chk_out("s38_ones_latch", 4'hF, 7'h7F, 1'b1);
    cyc(1); chk_out("s39_ones", 4'hB, 7'h78, 1'b0);
    ovr_en = 1'b1; ovr_val = 4'd8;
    cyc(1); chk_out("s40_ones_noghost", 4'hB, 7'h78, 1'b0);
    cyc(3); chk_out("s43_frac_new", 4'hD, 7'h00, 1'b1);
    ovr_en = 1'b0;

    cyc(16); chk_out("s59_frac", 4'hD, 7'h12, 1'b1);
    enable = 1'b0;
    cyc(1); chk_out("s60_disabled", 4'hF, 7'h7F, 1'b1);
    chk("s60.select", 32'(select), 32'h3);
    tbl[3] = 4'd1;
    cyc(4); chk("s64.select", 32'(select), 32'h3);
    chk("s64.digit_en", 32'(digit_en), 32'hF);
    chk("s64.frame_tick", 32'(frame_tick), 32'h0);
    enable = 1'b1;
    cyc(1); chk_out("s65_reen_blank", 4'hF, 7'h7F, 1'b1);
    cyc(2); chk_out("s67_reen_tens", 4'h7, 7'h79, 1'b1);

    #2 reset = 1'b1;
    #1 chk_out("async_reset", 4'hF, 7'h7F, 1'b1);
    chk("async_reset.select", 32'(select), 32'h3);
    cyc(2);
    reset = 1'b0;
    cyc(2); chk_out("post_reset_latch", 4'hF, 7'h7F, 1'b1);
    cyc(1); chk_out("post_reset_tens", 4'h7, 7'h79, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
